// File: rtl/spi_slave_port.sv
// SPI responder: oversamples SCLK/SS/MOSI on clk_i, shifts bytes MSB-first in both
// directions and trades bytes with the system side through valid/ready handshakes.
module spi_slave_port #(
  parameter bit         CPOL        = 1'b0,
  parameter bit         CPHA        = 1'b0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       frame_abort_o,
  output logic       busy_o
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
  logic [7:0]             hold_q, hold_d, tx_sr_q, tx_sr_d;
  logic [7:0]             rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic                   hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   underrun_q, underrun_d, overrun_q, overrun_d;
  logic                   abort_q, abort_d;

  logic       sclk_s, ss_s, mosi_s, ss_fall, ss_rise, active;
  logic       lead, trail, sample_e, shift_e, tx_load, tx_accept, rx_clr;
  logic [7:0] rx_byte;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall = ss_prev_q & ~ss_s;
  assign ss_rise = ~ss_prev_q & ss_s;
  // SCLK edges only count inside a frame that was opened by a seen SS fall
  assign active  = (state_q == ACTIVE) & ~ss_s;
  assign lead    = active & (sclk_prev_q == CPOL) & (sclk_s != CPOL);
  assign trail   = active & (sclk_prev_q != CPOL) & (sclk_s == CPOL);
  assign sample_e = CPHA ? trail : lead;
  assign shift_e  = CPHA ? lead : trail;
  assign tx_load  = CPHA ? (lead & (bit_cnt_q == 3'd0))
                         : (ss_fall | (trail & (bit_cnt_q == 3'd0)));
  assign tx_accept = tx_valid_i & ~hold_full_q;
  assign rx_clr    = rx_valid_q & rx_ready_i;
  assign rx_byte   = {rx_sr_q[6:0], mosi_s};

  always_comb begin
    state_d = state_q;
    if (ss_fall)      state_d = ACTIVE;
    else if (ss_rise) state_d = IDLE;

    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;

    // a load consumes the old holding contents even if a new byte arrives this cycle
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sr_d     = tx_sr_q;
    underrun_d  = 1'b0;
    if (tx_load) begin
      hold_full_d = 1'b0;
      underrun_d  = ~hold_full_q;
      tx_sr_d     = hold_full_q ? hold_q : IDLE_BYTE;
    end else if (shift_e) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end
    if (ss_rise) tx_sr_d = '0;
    if (tx_accept) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_clr;
    overrun_d  = 1'b0;
    abort_d    = 1'b0;
    if (ss_rise) begin
      rx_sr_d   = '0;
      bit_cnt_d = '0;
      abort_d   = (bit_cnt_q != 3'd0);
    end else if (sample_e) begin
      rx_sr_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (rx_valid_q & ~rx_clr) begin
          overrun_d = 1'b1;
        end else begin
          rx_data_d  = rx_byte;
          rx_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      ss_prev_q   <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
    end
  end

  assign busy_o        = (state_q == ACTIVE);
  assign spi_miso_oe_o = busy_o;
  assign spi_miso_o    = tx_sr_q[7] & busy_o;
  assign tx_ready_o    = ~hold_full_q;
  assign tx_underrun_o = underrun_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = overrun_q;
  assign frame_abort_o = abort_q;
endmodule
